lsu_mem_ctrl: RTL

- Load/store control stage directly upstream of the data memory; the only block that drives the data memory's mem_read, mem_write, mem_addr and mem_data_wr.
- Accepts one load or store per handshake from the execute/memory pipeline stage.
- Performs sign/zero extension for sub-dword loads.
- Memory supports only full 8-byte accesses, so sub-dword stores are done as read-modify-write.
- Returns load data and an error flag, with a one-cycle response pulse per request.

---
 rtl/lsu_mem_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of an 8-byte-wide data memory.
// Sub-dword stores are done as read-modify-write; sub-dword loads are extended here.
`ifndef D_WORD_WIDTH
`define D_WORD_WIDTH 64
`endif

module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W     = 64,
  parameter bit          SUBWORD_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [`D_WORD_WIDTH-1:0] req_wdata,
  output logic                     resp_valid,
  output logic [`D_WORD_WIDTH-1:0] resp_rdata,
  output logic                     resp_error,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [`D_WORD_WIDTH-1:0] mem_data_wr,
  input  logic [`D_WORD_WIDTH-1:0] mem_data_rd,
  input  logic                     dmem_error
);

  localparam int unsigned DW = `D_WORD_WIDTH;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [DW-1:0]     wdata_q, old_q, mem_data_wr_q;
  logic              err_q;

  logic          illegal;
  logic [DW-1:0] merge;
  logic [DW-1:0] load_ext;

  assign illegal = req_we ? (req_funct3[2] || (!SUBWORD_EN && (req_funct3[1:0] != 2'b11)))
                          : (req_funct3 == 3'b111);

  always_comb begin
    merge = wdata_q;
    unique case (funct3_q[1:0])
      2'b00:   merge = {old_q[DW-1:8],  wdata_q[7:0]};
      2'b01:   merge = {old_q[DW-1:16], wdata_q[15:0]};
      2'b10:   merge = {old_q[DW-1:32], wdata_q[31:0]};
      default: merge = wdata_q;
    endcase
  end

  always_comb begin
    load_ext = old_q;
    unique case (funct3_q)
      3'b000:  load_ext = {{(DW-8){old_q[7]}},   old_q[7:0]};
      3'b001:  load_ext = {{(DW-16){old_q[15]}}, old_q[15:0]};
      3'b010:  load_ext = {{(DW-32){old_q[31]}}, old_q[31:0]};
      3'b100:  load_ext = {{(DW-8){1'b0}},       old_q[7:0]};
      3'b101:  load_ext = {{(DW-16){1'b0}},      old_q[15:0]};
      3'b110:  load_ext = {{(DW-32){1'b0}},      old_q[31:0]};
      default: load_ext = old_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_error  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    // Memory-side address/data hold their last driven values between accesses.
    mem_addr    = mem_addr_q;
    mem_data_wr = mem_data_wr_q;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (illegal)                                  state_d = StResp;
          else if (req_we && (req_funct3[1:0] == 2'b11)) state_d = StWr;
          else                                          state_d = StRd;
        end
      end
      StRd: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        state_d  = (dmem_error || !we_q) ? StResp : StWr;
      end
      StWr: begin
        mem_write   = 1'b1;
        mem_addr    = addr_q;
        mem_data_wr = merge;
        state_d     = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (!we_q && !err_q) ? load_ext : '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= '0;
      old_q         <= '0;
      err_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_wr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= illegal;
      end
      if (state_q == StRd) begin
        old_q <= mem_data_rd;
        if (dmem_error) err_q <= 1'b1;
      end
      if (state_q == StWr) err_q <= dmem_error;
      if (mem_read || mem_write) mem_addr_q <= mem_addr;
      if (mem_write) mem_data_wr_q <= mem_data_wr;
    end
  end

endmodule
